ram_sdp_clear: RTL and testbench

RAM_SDP_CLEAR -- requirements
Module: ram_sdp_clear

---
 rtl/ram_sdp_clear_pkg.sv | 13 +
 rtl/ram_sdp_clear_core.sv | 39 +++
 rtl/ram_sdp_clear.sv | 188 ++++++++++++++++++
 tb/tb_ram_sdp_clear.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sdp_clear_pkg.sv
// Shared types and constants for the clearable simple-dual-port RAM.
// Holds the sweep FSM state encoding and the collision-mode selectors.
package ram_sdp_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int COLLISION_READ_OLD      = 0;
  localparam int COLLISION_WRITE_THROUGH = 1;

endpackage

// File: rtl/ram_sdp_clear_core.sv
// Bare storage array: byte-enable write port and registered read port.
// There is no reset, so the array maps onto block RAM.
module ram_sdp_core
  import ram_sdp_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8,
  parameter int MEMORY_DEPTH  = 2**ADDRESS_WIDTH
) (
  input  logic                             i_clk,
  input  logic                             i_writeEnable,
  input  logic [ADDRESS_WIDTH-1:0]         i_writeAddress,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_byteEnable,
  input  logic [DATA_WIDTH-1:0]            i_writeData,
  input  logic                             i_readEnable,
  input  logic [ADDRESS_WIDTH-1:0]         i_readAddress,
  output logic [DATA_WIDTH-1:0]            o_readData
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [MEMORY_DEPTH];

  // The read samples the array before this edge's write lands (read-old).
  always_ff @(posedge i_clk) begin
    if (i_writeEnable) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_byteEnable[l]) begin
          r_mem[i_writeAddress][l*BYTE_WIDTH +: BYTE_WIDTH] <= i_writeData[l*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
    if (i_readEnable) begin
      o_readData <= r_mem[i_readAddress];
    end
  end

endmodule

// File: rtl/ram_sdp_clear.sv
// Simple-dual-port RAM with a full-memory clear sweep after reset or on request,
// byte-enable writes, selectable read-old / write-through collisions and 1-2 cycle read latency.
module ram_sdp_clear
  import ram_sdp_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH  = 10,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    BYTE_WIDTH     = 8,
  parameter int                    MEMORY_DEPTH   = 2**ADDRESS_WIDTH,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    COLLISION_MODE = COLLISION_READ_OLD,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Clear_i,
  input  logic                             ReadEnable_i,
  input  logic [ADDRESS_WIDTH-1:0]         ReadAddress_i,
  input  logic                             WriteEnable_i,
  input  logic [ADDRESS_WIDTH-1:0]         WriteAddress_i,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] ByteEnable_i,
  input  logic [DATA_WIDTH-1:0]            Data_i,
  output logic [DATA_WIDTH-1:0]            Data_o,
  output logic                             DataValid_o,
  output logic                             Busy_o
);

  localparam int                     LANES       = DATA_WIDTH / BYTE_WIDTH;
  localparam int                     INDEX_WIDTH = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W     = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);

  if (MEMORY_DEPTH > 2**ADDRESS_WIDTH) begin : g_badDepth
    $fatal(1, "ram_sdp_clear: MEMORY_DEPTH exceeds 2**ADDRESS_WIDTH");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_badLanes
    $fatal(1, "ram_sdp_clear: DATA_WIDTH is not a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_badLatency
    $fatal(1, "ram_sdp_clear: READ_LATENCY must be 1 or 2");
  end

  state_t                  r_state;
  state_t                  w_stateNext;
  logic [ADDRESS_WIDTH:0]  r_count;
  logic [ADDRESS_WIDTH:0]  w_countNext;

  logic                    w_busy;
  logic                    w_readInRange;
  logic                    w_writeInRange;
  logic                    w_userRead;
  logic                    w_userWrite;
  logic                    w_collide;

  logic                    w_coreWe;
  logic [INDEX_WIDTH-1:0]  w_coreWaddr;
  logic [LANES-1:0]        w_coreBe;
  logic [DATA_WIDTH-1:0]   w_coreWdata;
  logic                    w_coreRe;
  logic [DATA_WIDTH-1:0]   w_coreData;

  logic                    r_s1Valid;
  logic                    r_s1Zero;
  logic                    r_s1Collide;
  logic [LANES-1:0]        r_s1ByteEnable;
  logic [DATA_WIDTH-1:0]   r_s1Data;
  logic [DATA_WIDTH-1:0]   w_merged;
  logic [DATA_WIDTH-1:0]   w_s1Word;

  assign w_busy         = (r_state == ST_CLEAR);
  assign Busy_o         = w_busy;
  assign w_readInRange  = ({1'b0, ReadAddress_i} < DEPTH_W);
  assign w_writeInRange = ({1'b0, WriteAddress_i} < DEPTH_W);
  assign w_userRead     = !Reset && !w_busy && ReadEnable_i;
  assign w_userWrite    = !Reset && !w_busy && WriteEnable_i && w_writeInRange;
  assign w_collide      = w_userRead && w_userWrite && (ReadAddress_i == WriteAddress_i);

  // The sweep owns the write port while busy; user traffic is simply not accepted.
  assign w_coreWe    = !Reset && (w_busy || w_userWrite);
  assign w_coreWaddr = w_busy ? r_count[INDEX_WIDTH-1:0] : WriteAddress_i[INDEX_WIDTH-1:0];
  assign w_coreBe    = w_busy ? {LANES{1'b1}} : ByteEnable_i;
  assign w_coreWdata = w_busy ? CLEAR_VALUE : Data_i;
  assign w_coreRe    = w_userRead && w_readInRange;

  ram_sdp_core #(
    .ADDRESS_WIDTH (INDEX_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .BYTE_WIDTH    (BYTE_WIDTH),
    .MEMORY_DEPTH  (MEMORY_DEPTH)
  ) u_core (
    .i_clk          (Clock),
    .i_writeEnable  (w_coreWe),
    .i_writeAddress (w_coreWaddr),
    .i_byteEnable   (w_coreBe),
    .i_writeData    (w_coreWdata),
    .i_readEnable   (w_coreRe),
    .i_readAddress  (ReadAddress_i[INDEX_WIDTH-1:0]),
    .o_readData     (w_coreData)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_CLEAR;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      ST_CLEAR: begin
        w_countNext = r_count + 1'b1;
        if (r_count == DEPTH_W - 1'b1) begin
          w_stateNext = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (Clear_i) begin
          w_countNext = '0;
          w_stateNext = ST_CLEAR;
        end
      end
      default: begin
        w_stateNext = ST_CLEAR;
        w_countNext = '0;
      end
    endcase
  end

  // Side information for the last accepted read; held between reads so Data_o stays stable.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_s1Valid      <= 1'b0;
      r_s1Zero       <= 1'b1;
      r_s1Collide    <= 1'b0;
      r_s1ByteEnable <= '0;
      r_s1Data       <= '0;
    end else begin
      r_s1Valid <= w_userRead;
      if (w_userRead) begin
        r_s1Zero       <= !w_readInRange;
        r_s1Collide    <= w_collide;
        r_s1ByteEnable <= ByteEnable_i;
        r_s1Data       <= Data_i;
      end
    end
  end

  always_comb begin
    w_merged = w_coreData;
    for (int l = 0; l < LANES; l++) begin
      if (r_s1ByteEnable[l]) begin
        w_merged[l*BYTE_WIDTH +: BYTE_WIDTH] = r_s1Data[l*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign w_s1Word = r_s1Zero ? '0 :
                    ((COLLISION_MODE == COLLISION_WRITE_THROUGH) && r_s1Collide) ? w_merged :
                    w_coreData;

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic                  r_validOut;

    always_ff @(posedge Clock) begin
      if (Reset) begin
        r_dataOut  <= '0;
        r_validOut <= 1'b0;
      end else begin
        r_validOut <= r_s1Valid;
        if (r_s1Valid) begin
          r_dataOut <= w_s1Word;
        end
      end
    end

    assign Data_o      = r_dataOut;
    assign DataValid_o = r_validOut;
  end else begin : g_lat1
    assign Data_o      = w_s1Word;
    assign DataValid_o = r_s1Valid;
  end

endmodule

// File: tb/tb_ram_sdp_clear.sv
// Bench for ram_sdp_clear: two instances (latency 1 / read-old / clear 0 and
// latency 2 / write-through / clear 0x5A5A5A5A) driven together against a word-level model.
module tb_ram_sdp_clear;

  localparam int AW    = 5;
  localparam int DEPTH = 16;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Clear_i;
  logic        ReadEnable_i;
  logic [AW-1:0] ReadAddress_i;
  logic        WriteEnable_i;
  logic [AW-1:0] WriteAddress_i;
  logic [3:0]  ByteEnable_i;
  logic [31:0] Data_i;

  logic [31:0] dataA, dataB;
  logic        validA, validB, busyA, busyB;

  logic [31:0] mMem [2][DEPTH];
  bit          mBusy [2];
  int          mCnt [2];
  logic [31:0] mData [2];
  bit          mValid [2];
  bit          mSlotV [2];
  logic [31:0] mSlotD [2];

  int testsRun = 0;
  int testsFailed = 0;

  always #5 Clock = ~Clock;

  ram_sdp_clear #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMORY_DEPTH(DEPTH),
    .READ_LATENCY(1), .COLLISION_MODE(0), .CLEAR_VALUE(32'h0000_0000)
  ) dutA (
    .Clock(Clock), .Reset(Reset), .Clear_i(Clear_i),
    .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i),
    .WriteEnable_i(WriteEnable_i), .WriteAddress_i(WriteAddress_i),
    .ByteEnable_i(ByteEnable_i), .Data_i(Data_i),
    .Data_o(dataA), .DataValid_o(validA), .Busy_o(busyA)
  );

  ram_sdp_clear #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(32), .BYTE_WIDTH(8), .MEMORY_DEPTH(DEPTH),
    .READ_LATENCY(2), .COLLISION_MODE(1), .CLEAR_VALUE(32'h5A5A_5A5A)
  ) dutB (
    .Clock(Clock), .Reset(Reset), .Clear_i(Clear_i),
    .ReadEnable_i(ReadEnable_i), .ReadAddress_i(ReadAddress_i),
    .WriteEnable_i(WriteEnable_i), .WriteAddress_i(WriteAddress_i),
    .ByteEnable_i(ByteEnable_i), .Data_i(Data_i),
    .Data_o(dataB), .DataValid_o(validB), .Busy_o(busyB)
  );

  function automatic int latencyOf(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] clearOf(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) r[l*8 +: 8] = d[l*8 +: 8];
    end
    return r;
  endfunction

  // One rising edge of the behavioural model for instance i, using the inputs held across the edge.
  task automatic modelEdge(input int i);
    logic [31:0] rd;
    bit          acc;
    int          ra, wa;
    ra  = int'(ReadAddress_i);
    wa  = int'(WriteAddress_i);
    acc = 0;
    rd  = '0;
    if (Reset) begin
      mBusy[i]  = 1;
      mCnt[i]   = 0;
      mData[i]  = '0;
      mValid[i] = 0;
      mSlotV[i] = 0;
      return;
    end
    if (mBusy[i]) begin
      mMem[i][mCnt[i]] = clearOf(i);
      if (mCnt[i] == DEPTH - 1) mBusy[i] = 0;
      mCnt[i]++;
    end else begin
      if (ReadEnable_i) begin
        acc = 1;
        if (ra < DEPTH) begin
          rd = mMem[i][ra];
          if (i == 1 && WriteEnable_i && wa == ra) rd = mergeBytes(rd, Data_i, ByteEnable_i);
        end
      end
      if (WriteEnable_i && wa < DEPTH) mMem[i][wa] = mergeBytes(mMem[i][wa], Data_i, ByteEnable_i);
      if (Clear_i) begin
        mBusy[i] = 1;
        mCnt[i]  = 0;
      end
    end
    if (latencyOf(i) == 1) begin
      mValid[i] = acc;
      if (acc) mData[i] = rd;
    end else begin
      mValid[i] = mSlotV[i];
      if (mSlotV[i]) mData[i] = mSlotD[i];
      mSlotV[i] = acc;
      mSlotD[i] = rd;
    end
  endtask

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    checkBit ("busyA",  busyA,  mBusy[0]);
    checkBit ("validA", validA, mValid[0]);
    checkWord("dataA",  dataA,  mData[0]);
    checkBit ("busyB",  busyB,  mBusy[1]);
    checkBit ("validB", validB, mValid[1]);
    checkWord("dataB",  dataB,  mData[1]);
  endtask

  task automatic step();
    @(posedge Clock);
    modelEdge(0);
    modelEdge(1);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit rst, input bit clr, input bit re, input logic [AW-1:0] ra,
                               input bit we, input logic [AW-1:0] wa, input logic [3:0] be,
                               input logic [31:0] d);
    Reset          = rst;
    Clear_i        = clr;
    ReadEnable_i   = re;
    ReadAddress_i  = ra;
    WriteEnable_i  = we;
    WriteAddress_i = wa;
    ByteEnable_i   = be;
    Data_i         = d;
    step();
  endtask

  task automatic applyIdle();
    applyStimulus(0, 0, 0, '0, 0, '0, 4'h0, '0);
  endtask

  task automatic applyRead(input logic [AW-1:0] a);
    applyStimulus(0, 0, 1, a, 0, '0, 4'h0, '0);
  endtask

  task automatic applyWrite(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
    applyStimulus(0, 0, 0, '0, 1, a, be, d);
  endtask

  initial begin
    int n;
    bit re, we, clr, rst;
    logic [AW-1:0] ra, wa;

    // Reset pulse, then count the sweep length.
    applyStimulus(1, 0, 0, '0, 0, '0, 4'h0, '0);
    checkBit("busyAfterReset", busyA, 1'b1);
    n = 0;
    do begin
      applyIdle();
      n++;
    end while (busyA === 1'b1 && n < 40);
    checkWord("sweepLen", 32'(n), 32'd16);
    for (int a = 0; a < DEPTH; a++) applyRead(AW'(a));
    applyIdle();
    applyIdle();

    // Reset five cycles into a sweep; a write issued while busy must vanish.
    applyStimulus(1, 0, 0, '0, 0, '0, 4'h0, '0);
    repeat (5) applyIdle();
    applyStimulus(1, 0, 0, '0, 0, '0, 4'h0, '0);
    n = 0;
    do begin
      if (n == 0) applyStimulus(0, 0, 1, 5'd2, 1, 5'd2, 4'hF, 32'hDEAD_BEEF);
      else applyIdle();
      n++;
    end while (busyA === 1'b1 && n < 40);
    checkWord("restartLen", 32'(n), 32'd16);
    applyRead(5'd2);
    checkWord("lostWriteA", dataA, 32'h0000_0000);
    applyIdle();
    checkWord("lostWriteB", dataB, 32'h5A5A_5A5A);

    // Byte-enable merge.
    applyWrite(5'd3, 4'hF, 32'h1122_3344);
    applyWrite(5'd3, 4'b0101, 32'hAABB_CCDD);
    applyRead(5'd3);
    checkWord("byteEnA", dataA, 32'h11BB_33DD);
    applyIdle();
    checkWord("byteEnB", dataB, 32'h11BB_33DD);

    // Back-to-back reads through the latency-2 pipeline.
    applyWrite(5'd1, 4'hF, 32'h0101_0101);
    applyWrite(5'd2, 4'hF, 32'h0202_0202);
    applyRead(5'd1);
    checkBit("lat2Early", validB, 1'b0);
    applyRead(5'd2);
    checkWord("lat2First", dataB, 32'h0101_0101);
    applyRead(5'd3);
    checkWord("lat2Second", dataB, 32'h0202_0202);
    applyIdle();
    checkWord("lat2Third", dataB, 32'h11BB_33DD);
    checkBit("lat2ThirdValid", validB, 1'b1);
    applyIdle();
    checkBit("lat2Done", validB, 1'b0);

    // Same-address read and write.
    applyWrite(5'd7, 4'hF, 32'h0000_0000);
    applyStimulus(0, 0, 1, 5'd7, 1, 5'd7, 4'hF, 32'h1234_5678);
    checkWord("collideA", dataA, 32'h0000_0000);
    applyIdle();
    checkWord("collideB", dataB, 32'h1234_5678);
    applyRead(5'd7);
    applyIdle();

    // Out-of-range write is dropped; out-of-range read returns zero with a strobe.
    applyWrite(5'd20, 4'hF, 32'hCAFE_BABE);
    applyRead(5'd20);
    checkWord("oorDataA", dataA, 32'h0000_0000);
    checkBit("oorValidA", validA, 1'b1);
    applyRead(5'd4);
    applyIdle();
    applyIdle();

    // Fill with ones, request a clear, read everything back.
    for (int a = 0; a < DEPTH; a++) applyWrite(AW'(a), 4'hF, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 0, '0, 0, '0, 4'h0, '0);
    n = 0;
    do begin
      applyStimulus(0, 1, 0, '0, 0, '0, 4'h0, '0);
      n++;
    end while (busyB === 1'b1 && n < 40);
    checkWord("clearLen", 32'(n), 32'd16);
    applyIdle();
    for (int a = 0; a < DEPTH; a++) applyRead(AW'(a));
    applyIdle();
    applyRead(5'd9);
    applyIdle();
    checkWord("clearB", dataB, 32'h5A5A_5A5A);

    // Random traffic with frequent collisions, out-of-range addresses and occasional clear/reset.
    for (int c = 0; c < 600; c++) begin
      re  = bit'($urandom_range(0, 1));
      we  = bit'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 19));
      wa  = ($urandom_range(0, 1) == 0) ? ra : AW'($urandom_range(0, 19));
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(rst, clr, re, ra, we, wa, 4'($urandom), $urandom);
    end
    repeat (3) applyIdle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
